// File: rtl/tile_stream_reorder.sv
// Raster-to-tile reorder buffer. Two banks each hold one band of TILE_H
// full rows; the writer fills one band while the reader walks the other
// tile by tile. Read data lands directly in a 2-entry skid FIFO that
// drives the outputs, so downstream backpressure never loses a pixel.
module tile_stream_reorder #(
  parameter int PIX_W      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int TILE_W     = 16,
  parameter int TILE_H     = 16,
  localparam int TX    = IMG_WIDTH / TILE_W,
  localparam int TY    = IMG_HEIGHT / TILE_H,
  localparam int BAND  = TILE_H * IMG_WIDTH,
  localparam int IDX_W = (TX * TY > 1) ? $clog2(TX * TY) : 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFlush,
  input  logic             iValid,
  output logic             oReady,
  input  logic [PIX_W-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [PIX_W-1:0] oData,
  output logic [IDX_W-1:0] oTile_idx,
  output logic             oTile_last,
  output logic             oFrame_last
);

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW  = cw(2 * BAND);
  localparam int CW  = cw(IMG_WIDTH);
  localparam int RW  = cw(TILE_H);
  localparam int TCW = cw(TILE_W);
  localparam int TXW = cw(TX);
  localparam int TYW = cw(TY);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_FREE} rd_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             tlast;
    logic             flast;
  } out_t;

  logic [PIX_W-1:0] mem [2*BAND];

  logic           started;
  logic [1:0]     full;
  logic           wr_bank, rd_bank;
  logic [CW-1:0]  wr_col;
  logic [RW-1:0]  wr_row;
  rd_state_t      rd_state;
  logic [TCW-1:0] rd_col;
  logic [RW-1:0]  rd_row;
  logic [TXW-1:0] rd_tx;
  logic [TYW-1:0] rd_ty;

  out_t           fifo [2];
  logic           fifo_wp, fifo_rp;
  logic [1:0]     fifo_cnt;

  logic           wr_fire, wr_band_done, rd_fire, rd_band_done, pop;
  logic           col_last, row_last, tx_last, ty_last;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [IDX_W-1:0] rd_idx;

  assign oReady       = started & ~full[wr_bank];
  assign wr_fire      = iValid & oReady;
  assign wr_band_done = (wr_col == CW'(IMG_WIDTH-1)) && (wr_row == RW'(TILE_H-1));
  assign wr_addr      = (wr_bank ? AW'(BAND) : AW'(0)) + AW'(wr_row) * AW'(IMG_WIDTH)
                      + AW'(wr_col);

  assign col_last     = rd_col == TCW'(TILE_W-1);
  assign row_last     = rd_row == RW'(TILE_H-1);
  assign tx_last      = rd_tx == TXW'(TX-1);
  assign ty_last      = rd_ty == TYW'(TY-1);
  // The FIFO slot is the RAM's read register, so nothing is ever in flight
  // outside the FIFO and occupancy alone gates issue.
  assign rd_fire      = (rd_state == R_RUN) && (fifo_cnt != 2'd2);
  assign rd_band_done = rd_fire && col_last && row_last && tx_last;
  assign rd_addr      = (rd_bank ? AW'(BAND) : AW'(0)) + AW'(rd_row) * AW'(IMG_WIDTH)
                      + AW'(rd_tx) * AW'(TILE_W) + AW'(rd_col);
  assign rd_idx       = IDX_W'(rd_ty) * IDX_W'(TX) + IDX_W'(rd_tx);

  assign pop          = oValid & iReady;
  assign oValid       = fifo_cnt != 2'd0;
  assign oData        = fifo[fifo_rp].data;
  assign oTile_idx    = fifo[fifo_rp].idx;
  assign oTile_last   = fifo[fifo_rp].tlast;
  assign oFrame_last  = fifo[fifo_rp].flast;

  // Pixel storage; contents are don't-care after reset or flush
  always_ff @(posedge iClk) begin
    if (wr_fire) mem[wr_addr] <= iData;
  end

  // Write counters, bank full marks and the read walker
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      started  <= 1'b0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_col   <= '0;
      wr_row   <= '0;
      rd_state <= R_IDLE;
      rd_col   <= '0;
      rd_row   <= '0;
      rd_tx    <= '0;
      rd_ty    <= '0;
    end else if (iFlush) begin
      started  <= 1'b0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_col   <= '0;
      wr_row   <= '0;
      rd_state <= R_IDLE;
      rd_col   <= '0;
      rd_row   <= '0;
      rd_tx    <= '0;
      rd_ty    <= '0;
    end else begin
      started <= 1'b1;
      if (wr_fire) begin
        if (wr_col == CW'(IMG_WIDTH-1)) begin
          wr_col <= '0;
          wr_row <= (wr_row == RW'(TILE_H-1)) ? '0 : wr_row + RW'(1);
        end else begin
          wr_col <= wr_col + CW'(1);
        end
        // Writer only ever targets an empty bank, reader only frees a full
        // one, so set and clear below never hit the same bank together.
        if (wr_band_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      case (rd_state)
        R_IDLE: if (full[rd_bank]) rd_state <= R_RUN;
        R_RUN: begin
          if (rd_fire) begin
            rd_col <= col_last ? '0 : rd_col + TCW'(1);
            if (col_last) begin
              rd_row <= row_last ? '0 : rd_row + RW'(1);
              if (row_last) rd_tx <= tx_last ? '0 : rd_tx + TXW'(1);
            end
          end
          if (rd_band_done) rd_state <= R_FREE;
        end
        R_FREE: begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_ty         <= ty_last ? '0 : rd_ty + TYW'(1);
          rd_state      <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Output skid FIFO, written straight from the RAM read port
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else if (iFlush) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      if (rd_fire) begin
        fifo[fifo_wp] <= {mem[rd_addr], rd_idx, col_last && row_last,
                          col_last && row_last && tx_last && ty_last};
        fifo_wp       <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      case ({rd_fire, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_stream_reorder.sv
// Bench for tile_stream_reorder on an 8x4 image of 4x2 tiles. Expected
// output is built from a frame image by walking tiles in order.
module tb_tile_stream_reorder;
  localparam int PIX_W = 8, W = 8, H = 4, TW = 4, TH = 2;
  localparam int TXN = W / TW, TYN = H / TH, NPIX = W * H, IDX_W = 2;
  localparam int EW = PIX_W + IDX_W + 2;

  logic iClk = 1'b0, iRst = 1'b0, iFlush = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [PIX_W-1:0] iData = '0;
  logic oReady, oValid, oTile_last, oFrame_last;
  logic [PIX_W-1:0] oData;
  logic [IDX_W-1:0] oTile_idx;

  tile_stream_reorder #(.PIX_W(PIX_W), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                        .TILE_W(TW), .TILE_H(TH)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData),
    .oTile_idx(oTile_idx), .oTile_last(oTile_last), .oFrame_last(oFrame_last));

  always #5 iClk = ~iClk;

  int ntests = 0, nfail = 0, nout = 0, rmode = 0;
  bit mon_en = 1'b0, stall_prev = 1'b0;
  logic [EW-1:0] held;
  logic [PIX_W-1:0] frm [NPIX];
  logic [PIX_W-1:0] inq [$];
  logic [EW-1:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < NPIX; i++) frm[i] = rnd ? PIX_W'($urandom) : PIX_W'(i);
  endtask

  task automatic load_inq();
    for (int i = 0; i < NPIX; i++) inq.push_back(frm[i]);
  endtask

  // Tile-major walk of the current frame image
  task automatic model_frame();
    logic tl, fl;
    logic [IDX_W-1:0] idx;
    for (int ty = 0; ty < TYN; ty++)
      for (int tx = 0; tx < TXN; tx++)
        for (int r = 0; r < TH; r++)
          for (int c = 0; c < TW; c++) begin
            idx = IDX_W'(ty * TXN + tx);
            tl  = (r == TH-1) && (c == TW-1);
            fl  = tl && (ty * TXN + tx == TXN * TYN - 1);
            expq.push_back({frm[(ty*TH + r)*W + tx*TW + c], idx, tl, fl});
          end
  endtask

  // Present queued pixels; a pixel leaves the queue when accepted
  task automatic feed(input int budget);
    int cyc = 0;
    bit acc;
    while (inq.size() > 0 && cyc < budget) begin
      iValid = 1'b1;
      iData  = inq[0];
      @(negedge iClk);
      acc = oReady;
      step();
      cyc++;
      if (acc) void'(inq.pop_front());
    end
    iValid = 1'b0;
    chk("feed_done", inq.size(), 0);
    inq.delete();
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    while (expq.size() > 0 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("drain_all_out", expq.size(), 0);
    expq.delete();
    step();
    step();
    chk("drain_idle", oValid, 0);
  endtask

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled
  initial forever begin
    @(posedge iClk);
    #1;
    case (rmode)
      0:       iReady = 1'b1;
      1:       iReady = 1'($urandom_range(0, 1));
      default: iReady = 1'b0;
    endcase
  end

  // Output monitor: order/flag check on every transfer, hold check on stalls
  always @(negedge iClk) begin
    logic [EW-1:0] e;
    if (!mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", oValid, 1);
        chk("stall_hold", {oData, oTile_idx, oTile_last, oFrame_last}, held);
      end
      if (oValid && iReady) begin
        chk("out_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_data", oData, e[EW-1 -: PIX_W]);
          chk("out_idx_flags", {oTile_idx, oTile_last, oFrame_last}, e[IDX_W+1:0]);
        end
        nout++;
      end
      stall_prev = oValid && !iReady;
      held = {oData, oTile_idx, oTile_last, oFrame_last};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;
    // Reset state and one-cycle oReady delay after release
    repeat (3) step();
    chk("rst_valid", oValid, 0);
    chk("rst_data", oData, 0);
    chk("rst_idx", oTile_idx, 0);
    chk("rst_tlast", oTile_last, 0);
    chk("rst_flast", oFrame_last, 0);
    chk("rst_ready", oReady, 0);
    iRst = 1'b1;
    chk("rel_ready_low", oReady, 0);
    step();
    chk("rel_ready_high", oReady, 1);
    mon_en = 1'b1;

    // Raster-index frame, downstream always ready
    fill(0); model_frame(); load_inq();
    feed(500); drain(500);

    // Random data, random backpressure
    rmode = 1;
    fill(1); model_frame(); load_inq();
    feed(500); drain(1000);

    // Stalled downstream: both banks fill, then release
    rmode = 2;
    step();
    fill(1); model_frame(); load_inq();
    base = nout;
    feed(500);
    repeat (4) begin
      step();
      chk("bp_ready_low", oReady, 0);
    end
    chk("bp_no_output", nout - base, 0);
    chk("bp_valid_held", oValid, 1);
    rmode = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = oReady;
    end
    chk("bp_ready_rise", seen, 1);
    chk("bp_ready_after_band0", nout - base, TXN * TW * TH);
    drain(500);

    // Two back-to-back frames
    rmode = 1;
    fill(1); model_frame(); load_inq();
    fill(1); model_frame(); load_inq();
    feed(1000); drain(1000);

    // Async reset mid-band
    rmode = 0;
    for (int i = 0; i < 5; i++) inq.push_back(PIX_W'($urandom));
    feed(100);
    mon_en = 1'b0;
    iRst = 1'b0;
    #1;
    chk("mid_rst_valid", oValid, 0);
    chk("mid_rst_data", oData, 0);
    chk("mid_rst_idx", oTile_idx, 0);
    chk("mid_rst_flags", {oTile_last, oFrame_last}, 0);
    chk("mid_rst_ready", oReady, 0);
    step();
    iRst = 1'b1;
    step();
    mon_en = 1'b1;
    fill(0); model_frame(); load_inq();
    feed(500); drain(500);

    // Flush while output is valid
    rmode = 2;
    step();
    fill(1); load_inq();
    feed(500);
    step();
    chk("fl_pre_valid", oValid, 1);
    mon_en = 1'b0;
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    chk("fl_valid_clear", oValid, 0);
    chk("fl_data_clear", oData, 0);
    chk("fl_ready_low", oReady, 0);
    step();
    chk("fl_ready_back", oReady, 1);
    chk("fl_banks_empty", oValid, 0);
    mon_en = 1'b1;
    rmode = 1;
    fill(1); model_frame(); load_inq();
    feed(500); drain(1000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/tile_stream_reorder.md
Name: tile_stream_reorder

Overview:
- Converts a raster-scan pixel stream into tile-major order (TILE_W x TILE_H tiles, left-to-right, then top-to-bottom) for the downstream per-tile processing engines.
- Buffers one band (TILE_H full image rows) per bank in a two-bank ping-pong RAM. One band is written while the other is read out.
- Both sides use valid/ready handshakes with full backpressure. The output carries a tile index and last flags, replacing a free-running done counter.

Parameters:
- PIX_W, 8, pixel width in bits
- IMG_WIDTH, 640, image width in pixels; must be a multiple of TILE_W
- IMG_HEIGHT, 480, image height in pixels; must be a multiple of TILE_H
- TILE_W, 16, tile width in pixels
- TILE_H, 16, tile height in pixels
- Derived: TX=IMG_WIDTH/TILE_W; TY=IMG_HEIGHT/TILE_H; BAND=TILE_H*IMG_WIDTH; IDX_W=clog2(TX*TY)

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous active-low reset
- iFlush  in  1  synchronous clear of all state; pixel data is not preserved
- iValid  in  1  input pixel valid
- oReady  out  1  input ready
- iData  in  PIX_W  input pixel, raster order
- oValid  out  1  output pixel valid
- iReady  in  1  downstream ready
- oData  out  PIX_W  output pixel, tile order
- oTile_idx  out  IDX_W  tile index ty*TX+tx of the current pixel
- oTile_last  out  1  marks the last pixel of a tile
- oFrame_last  out  1  marks the last pixel of the frame

Behaviour:
- Reset: when iRst=0, the block clears asynchronously. When iFlush=1, it applies the same clear on the next clock edge. Clear values:
  - oReady=0 for one cycle after reset release, then 1.
  - oValid=0, oData=0, oTile_idx=0, oTile_last=0, oFrame_last=0.
  - Both banks empty; writer and reader on bank 0; all counters 0.
- Write side:
  - A transfer occurs when iValid&&oReady.
  - Address = bank*BAND + wr_row*IMG_WIDTH + wr_col.
  - wr_col wraps at IMG_WIDTH-1. wr_row wraps at TILE_H-1.
  - On the band's final transfer, the bank is marked full and the writer toggles to the other bank.
  - oReady=1 iff the writer's current bank is empty.
- Write-side boundary cases:
  - If the target bank is still full, oReady=0 until the reader frees it. oReady rises the cycle after the free.
  - Band count wraps at TY-1. There is no start-of-frame marker; frames are back-to-back.
- Read FSM states:
  - R_IDLE: wait until the reader's bank is full, then go to R_RUN.
  - R_RUN: issue one read per cycle while the pipeline has space.
    - Address = bank*BAND + row*IMG_WIDTH + tx*TILE_W + col.
    - col wraps at TILE_W-1, then row increments. row wraps at TILE_H-1, then tx increments.
    - After the read at tx=TX-1, row=TILE_H-1, col=TILE_W-1, go to R_FREE.
  - R_FREE: one cycle. Mark the bank empty, toggle the reader bank, increment ty (wraps at TY-1), then go to R_IDLE.
- Read pipeline:
  - The RAM has 1-cycle read latency. It feeds a 2-entry output skid FIFO, which drives oData and the flags.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2. No data is ever dropped under backpressure.
  - Latency: the first pixel of a band has oValid=1 two cycles after the bank is marked full (1 cycle R_IDLE→R_RUN, 1 cycle RAM).
  - With iReady held at 1, output is 1 pixel/cycle within a band, with a 2-cycle bubble at each band boundary.
- Output flags and stability:
  - oData, oTile_idx and the flags hold stable while oValid&&!iReady.
  - oTile_last=1 when row=TILE_H-1 and col=TILE_W-1.
  - oFrame_last=1 when oTile_last=1 and the tile is tile TX*TY-1.
- Simultaneous events:
  - If R_FREE coincides with the writer's wait on that bank: the free wins, and the write proceeds the next cycle.
  - A bank's full and empty marks never change in the same cycle.
  - A flush overrides every other event in the same cycle.
- Width rules: all address and counter widths are clog2-sized from the parameters. No truncation is permitted at the default 640x480.

Test Plan:
- Small config (PIX_W=8, IMG_WIDTH=8, IMG_HEIGHT=4, TILE_W=4, TILE_H=2); pixel value = raster index 0..31; iReady=1:
  - Tile 0 outputs 0,1,2,3,8,9,10,11.
  - Tile 1 outputs 4..7,12..15.
  - Tile 2 outputs 16..19,24..27.
  - Tile 3 outputs 20..23,28..31.
  - oTile_last on the 8th, 16th, 24th and 32nd pixels; oFrame_last only on pixel 31.
- Same config, iReady toggled randomly 50% -> identical output sequence, no loss or duplication, outputs stable while stalled.
- Same config, iReady=0 and iValid=1 continuously -> oReady falls after input pixel 31 (both banks full). Raising iReady -> oReady returns 1 cycle after tile 1's last pixel is read.
- Same config, two back-to-back frames -> oTile_idx sequence 0,1,2,3,0,1,2,3; second frame data is correct.
- iRst pulsed low mid-band (after 5 input pixels) -> all outputs 0 immediately. After release, a fresh frame produces the first-test sequence exactly.
- iFlush for 1 cycle while oValid=1 -> oValid=0 next cycle, oReady=1 the following cycle, banks empty. A subsequent frame is correct.
